// File: rtl/booth_window_sequencer_if.sv
// Operand-in / window-out handshake bundle for the booth window sequencer.
// The slave modport is the sequencer side; master is the upstream/downstream side.
interface booth_window_sequencer_if #(
  parameter int WIDTH = 24
);
  localparam int NDIG = WIDTH / 3;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             win_valid;
  logic             win_ready;
  logic [3:0]       win_data;
  logic [IDXW-1:0]  win_idx;
  logic             win_last;

  modport slave (
    input  in_valid, in_data, win_ready,
    output in_ready, win_valid, win_data, win_idx, win_last
  );

  modport master (
    output in_valid, in_data, win_ready,
    input  in_ready, win_valid, win_data, win_idx, win_last
  );
endinterface

// File: rtl/booth_window_sequencer.sv
// Splits a WIDTH-bit operand into NDIG overlapping {3 new bits, overlap bit}
// windows, LSB first, one per accepted beat, for the downstream booth recoder.
module booth_window_sequencer #(
  parameter int WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  booth_window_sequencer_if.slave  bus
);
  localparam int NDIG = WIDTH / 3;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] sh;
  logic             prev;
  logic [IDXW-1:0]  idx;
  logic             run;
  logic             last;
  logic             beat;

  assign run  = (state == S_RUN);
  assign last = run && (idx == LAST_IDX);
  assign beat = run && bus.win_ready;

  // Every output decodes from registered state only.
  assign bus.in_ready  = !run;
  assign bus.win_valid = run;
  assign bus.win_data  = run ? {sh[2:0], prev} : 4'b0000;
  assign bus.win_idx   = idx;
  assign bus.win_last  = last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      sh    <= '0;
      prev  <= 1'b0;
      idx   <= '0;
    end else if (!run) begin
      if (bus.in_valid) begin
        sh    <= bus.in_data;
        prev  <= 1'b0;
        idx   <= '0;
        state <= S_RUN;
      end
    end else if (beat) begin
      // Top bit of this window becomes the overlap bit of the next one.
      prev <= sh[2];
      sh   <= sh >> 3;
      if (last) begin
        idx   <= '0;
        state <= S_IDLE;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_booth_window_sequencer.sv
// Directed-vector bench for booth_window_sequencer at WIDTH=24 and WIDTH=6.
module tb_booth_window_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  booth_window_sequencer_if #(.WIDTH(24)) b24 ();
  booth_window_sequencer_if #(.WIDTH(6))  b6 ();

  booth_window_sequencer #(.WIDTH(24)) u24 (.clk(clk), .rst_n(rst_n), .bus(b24));
  booth_window_sequencer #(.WIDTH(6))  u6  (.clk(clk), .rst_n(rst_n), .bus(b6));

  // Offer an operand to the 24-bit DUT and return at the negedge where window 0 shows.
  task automatic offer24(input logic [23:0] d, input bit keep_valid);
    bit ok = 0;
    @(negedge clk);
    b24.in_valid = 1'b1;
    b24.in_data  = d;
    for (int n = 0; n < 20; n++) begin
      if (b24.in_ready === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    total++;
    if (!ok) begin bad++; $display("FAIL offer_timeout in_ready never high"); end
    @(negedge clk);
    if (!keep_valid) b24.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b24.in_valid = 0; b24.in_data = '0; b24.win_ready = 0;
    b6.in_valid  = 0; b6.in_data  = '0; b6.win_ready  = 0;
    #1;
    total++;
    if ({b24.in_ready, b24.win_valid, b24.win_data, b24.win_idx, b24.win_last} !== {1'b1, 1'b0, 4'h0, 3'd0, 1'b0}) begin
      bad++; $display("FAIL reset24 got rdy=%b vld=%b data=%h idx=%0d last=%b exp 1 0 0 0 0",
        b24.in_ready, b24.win_valid, b24.win_data, b24.win_idx, b24.win_last);
    end
    total++;
    if ({b6.in_ready, b6.win_valid, b6.win_data, b6.win_idx, b6.win_last} !== {1'b1, 1'b0, 4'h0, 1'd0, 1'b0}) begin
      bad++; $display("FAIL reset6 got rdy=%b vld=%b data=%h idx=%0d last=%b exp 1 0 0 0 0",
        b6.in_ready, b6.win_valid, b6.win_data, b6.win_idx, b6.win_last);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_low_nibble();
    logic [7:0][3:0] exp = {4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h3, 4'hE};
    b24.win_ready = 1'b1;
    offer24(24'h00000F, 0);
    for (int k = 0; k < 8; k++) begin
      total++;
      if (b24.win_valid !== 1'b1 || b24.win_data !== exp[k] || b24.win_idx !== 3'(k) || b24.win_last !== (k == 7)) begin
        bad++; $display("FAIL nib_win k=%0d got vld=%b data=%h idx=%0d last=%b exp data=%h",
          k, b24.win_valid, b24.win_data, b24.win_idx, b24.win_last, exp[k]);
      end
      @(negedge clk);
    end
    total++;
    if (b24.in_ready !== 1'b1 || b24.win_valid !== 1'b0) begin
      bad++; $display("FAIL nib_idle got rdy=%b vld=%b exp 1 0", b24.in_ready, b24.win_valid);
    end
  endtask

  task automatic test_all_ones();
    b24.win_ready = 1'b1;
    offer24(24'hFFFFFF, 0);
    for (int k = 0; k < 8; k++) begin
      total++;
      if (b24.win_data !== ((k == 0) ? 4'hE : 4'hF) || b24.win_idx !== 3'(k) || b24.win_last !== (k == 7)) begin
        bad++; $display("FAIL ones_win k=%0d got data=%h idx=%0d last=%b", k, b24.win_data, b24.win_idx, b24.win_last);
      end
      @(negedge clk);
    end
    total++;
    if (b24.in_ready !== 1'b1) begin bad++; $display("FAIL ones_ready got %b exp 1", b24.in_ready); end
  endtask

  task automatic test_backpressure();
    int seen = 0;
    b24.win_ready = 1'b1;
    offer24(24'h000001, 0);
    for (int k = 0; k < 8; k++) begin
      total++;
      if (b24.win_valid !== 1'b1 || b24.win_data !== ((k == 0) ? 4'h2 : 4'h0) || b24.win_idx !== 3'(k)) begin
        bad++; $display("FAIL bp_win k=%0d got vld=%b data=%h idx=%0d", k, b24.win_valid, b24.win_data, b24.win_idx);
      end
      if (k == 1) begin
        b24.win_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          total++;
          if (b24.win_valid !== 1'b1 || b24.win_data !== 4'h0 || b24.win_idx !== 3'd1 || b24.win_last !== 1'b0) begin
            bad++; $display("FAIL bp_hold got vld=%b data=%h idx=%0d last=%b exp 1 0 1 0",
              b24.win_valid, b24.win_data, b24.win_idx, b24.win_last);
          end
        end
        b24.win_ready = 1'b1;
      end
      if (b24.win_valid === 1'b1) seen++;
      @(negedge clk);
    end
    total++;
    if (seen != 8 || b24.win_valid !== 1'b0) begin
      bad++; $display("FAIL bp_count got beats=%0d vld_after=%b exp 8 0", seen, b24.win_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0][3:0] exp = {4'h1, 4'h9, 4'h8, 4'h6, 4'h4, 4'h2, 4'h5, 4'hC};
    b24.win_ready = 1'b1;
    offer24(24'h123456, 1);
    b24.in_data = 24'hABCDEF;
    for (int k = 0; k < 8; k++) begin
      total++;
      if (b24.win_data !== exp[k] || b24.win_idx !== 3'(k) || b24.in_ready !== 1'b0) begin
        bad++; $display("FAIL b2b_win k=%0d got data=%h idx=%0d rdy=%b exp data=%h", k, b24.win_data, b24.win_idx, b24.in_ready, exp[k]);
      end
      @(negedge clk);
    end
    total++;
    if (b24.in_ready !== 1'b1 || b24.win_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_bubble got rdy=%b vld=%b exp 1 0", b24.in_ready, b24.win_valid);
    end
    @(negedge clk);
    b24.in_valid = 1'b0;
    total++;
    if (b24.win_valid !== 1'b1 || b24.win_data !== 4'hE || b24.win_idx !== 3'd0) begin
      bad++; $display("FAIL b2b_next0 got vld=%b data=%h idx=%0d exp 1 e 0", b24.win_valid, b24.win_data, b24.win_idx);
    end
    @(negedge clk);
    total++;
    if (b24.win_data !== 4'hB || b24.win_idx !== 3'd1) begin
      bad++; $display("FAIL b2b_next1 got data=%h idx=%0d exp b 1", b24.win_data, b24.win_idx);
    end
    repeat (6) @(negedge clk);
    total++;
    if (b24.win_last !== 1'b1 || b24.win_idx !== 3'd7) begin
      bad++; $display("FAIL b2b_last got last=%b idx=%0d exp 1 7", b24.win_last, b24.win_idx);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    b24.win_ready = 1'b1;
    offer24(24'hFFFFFF, 0);
    repeat (4) @(negedge clk);
    total++;
    if (b24.win_idx !== 3'd4 || b24.win_data !== 4'hF) begin
      bad++; $display("FAIL rst_pre got idx=%0d data=%h exp 4 f", b24.win_idx, b24.win_data);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (b24.win_valid !== 1'b0 || b24.in_ready !== 1'b1 || b24.win_idx !== 3'd0 || b24.win_data !== 4'h0) begin
      bad++; $display("FAIL rst_mid got vld=%b rdy=%b idx=%0d data=%h exp 0 1 0 0",
        b24.win_valid, b24.in_ready, b24.win_idx, b24.win_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    offer24(24'hFFFFFF, 0);
    total++;
    if (b24.win_valid !== 1'b1 || b24.win_idx !== 3'd0 || b24.win_data !== 4'hE) begin
      bad++; $display("FAIL rst_restart got vld=%b idx=%0d data=%h exp 1 0 e", b24.win_valid, b24.win_idx, b24.win_data);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_width6();
    bit ok = 0;
    @(negedge clk);
    b6.win_ready = 1'b1;
    b6.in_valid  = 1'b1;
    b6.in_data   = 6'b101011;
    for (int n = 0; n < 20; n++) begin
      if (b6.in_ready === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    total++;
    if (!ok) begin bad++; $display("FAIL w6_offer_timeout in_ready never high"); end
    @(negedge clk);
    b6.in_valid = 1'b0;
    total++;
    if (b6.win_valid !== 1'b1 || b6.win_data !== 4'b0110 || b6.win_idx !== 1'd0 || b6.win_last !== 1'b0) begin
      bad++; $display("FAIL w6_win0 got vld=%b data=%b idx=%0d last=%b exp 1 0110 0 0",
        b6.win_valid, b6.win_data, b6.win_idx, b6.win_last);
    end
    @(negedge clk);
    total++;
    if (b6.win_valid !== 1'b1 || b6.win_data !== 4'b1010 || b6.win_idx !== 1'd1 || b6.win_last !== 1'b1) begin
      bad++; $display("FAIL w6_win1 got vld=%b data=%b idx=%0d last=%b exp 1 1010 1 1",
        b6.win_valid, b6.win_data, b6.win_idx, b6.win_last);
    end
    @(negedge clk);
    total++;
    if (b6.win_valid !== 1'b0 || b6.in_ready !== 1'b1) begin
      bad++; $display("FAIL w6_idle got vld=%b rdy=%b exp 0 1", b6.win_valid, b6.in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_low_nibble();
    test_all_ones();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_width6();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
